// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and AXI constants for the read-channel arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
  } rd_req_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rd_arbiter_rr_picker.sv
// rtl/axi_rd_arbiter_rr_picker.sv - combinational round-robin winner search
// Winner is the first requesting index at or after ptr, wrapping modulo NUM_MASTERS.
module rr_picker #(
  parameter int NUM_MASTERS = 3,
  parameter int PTR_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic                   gnt_valid,
  output logic [PTR_W-1:0]       gnt_idx
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_MASTERS);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin sharing of one AXI3 read channel, one burst outstanding
// Requester index travels on arid; read data is routed back to the latched owner.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ID_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*4-1:0]  m_len,
  input  logic [NUM_MASTERS*3-1:0]  m_size,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  input  logic [NUM_MASTERS-1:0]    m_rready,
  output logic [31:0]               m_rdata,
  output logic [1:0]                m_rresp,
  output logic                      m_rlast,
  output logic [ID_WIDTH-1:0]       arid,
  output logic [31:0]               araddr,
  output logic [3:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [ID_WIDTH-1:0]       rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam int PTR_W = $clog2(NUM_MASTERS);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  rd_req_t          req_q, req_d;

  logic             gnt_valid;
  logic [PTR_W-1:0] gnt_idx;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .PTR_W       (PTR_W)
  ) u_picker (
    .req       (m_req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    req_d   = req_q;
    case (state_q)
      ARB_IDLE: begin
        // Payload is captured here so a requester dropping m_req later cannot disturb AR.
        if (gnt_valid) begin
          owner_d    = gnt_idx;
          req_d.addr = m_addr[int'(gnt_idx)*32 +: 32];
          req_d.len  = m_len[int'(gnt_idx)*4 +: 4];
          req_d.size = m_size[int'(gnt_idx)*3 +: 3];
          state_d    = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (arready) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (rvalid && rready && rlast) begin
          ptr_d   = (owner_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    m_ack    = '0;
    m_rvalid = '0;
    rready   = 1'b0;
    if (state_q == ARB_ADDR && arready) begin
      m_ack[owner_q] = 1'b1;
    end
    if (state_q == ARB_DATA) begin
      rready            = m_rready[owner_q];
      m_rvalid[owner_q] = rvalid;
    end
  end

  assign arvalid = (state_q == ARB_ADDR);
  assign arid    = ID_WIDTH'(owner_q);
  assign araddr  = req_q.addr;
  assign arlen   = req_q.len;
  assign arsize  = req_q.size;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign m_rdata = rdata;
  assign m_rresp = rresp;
  assign m_rlast = rlast;

  // With a single burst in flight, any beat must carry the owner's id and arrive only in DATA.
  a_rid_owner: assert property (@(posedge clk) disable iff (reset)
    (state_q == ARB_DATA && rvalid) |-> (rid == arid));
  a_rvalid_in_data: assert property (@(posedge clk) disable iff (reset)
    rvalid |-> (state_q == ARB_DATA));

endmodule
